// File: rtl/seg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder_if
// Description : Bus bundle between a multiplexed 7-segment scan source and the
//               seg_scan_decoder monitor.
//               master : drives val/place, observes the decoded results.
//               slave  : samples val/place, drives the decoded results.
// Ports       : val[6:0]     active-low segments, bit 6 = A .. bit 0 = G
//               place[3:0]   active-low anode select (0111 = thousands)
//               thous/hund/tens/ones[3:0]  recovered digits
//               valid, frame_done, seg_err, place_err, display_off  status
// Revision    : 1.0  initial release
// ============================================================================
interface seg_scan_decoder_if;
  logic [6:0] val;
  logic [3:0] place;
  logic [3:0] thous;
  logic [3:0] hund;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       valid;
  logic       frame_done;
  logic       seg_err;
  logic       place_err;
  logic       display_off;

  modport master (
    output val, place,
    input  thous, hund, tens, ones, valid, frame_done, seg_err, place_err, display_off
  );

  modport slave (
    input  val, place,
    output thous, hund, tens, ones, valid, frame_done, seg_err, place_err, display_off
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Watches a scanned 7-segment bus, debounces each digit slot and
//               decodes the segment pattern back to BCD, rebuilding the four
//               displayed digits and reporting frame / error / blank status.
// Ports       : clk    system clock, rising edge
//               reset  synchronous active-high reset
//               bus    seg_scan_decoder_if.slave (val/place in, results out)
// Revision    : 1.0  initial release
// ============================================================================
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int BLANK_CYCLES  = 64
) (
  input  wire logic          clk,
  input  wire logic          reset,
  seg_scan_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_RUN  = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  localparam logic [7:0]  C_STABLE    = 8'(STABLE_CYCLES);
  localparam logic [7:0]  C_STABLE_M1 = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] C_BLANK     = 16'(BLANK_CYCLES);

  logic [6:0]  r_val_q, r_val_prev;
  logic [3:0]  r_place_q, r_place_prev;
  logic [7:0]  r_stable_cnt;
  logic [15:0] r_blank_cnt;
  logic [3:0]  r_seen;
  logic [3:0]  r_digit [4];
  state_t      r_state;
  logic        r_valid, r_frame_done, r_seg_err, r_place_err, r_display_off;

  // Returns {illegal, digit}. All-dark is a legal blank digit (F).
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b1111111: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  function automatic logic one_hot_low(input logic [3:0] p);
    one_hot_low = (p == 4'b0111) || (p == 4'b1011) || (p == 4'b1101) || (p == 4'b1110);
  endfunction

  logic        w_same, w_capture;
  logic        w_q_onehot, w_q_multi;
  logic        w_in_onehot, w_in_idle;
  logic [1:0]  w_slot;
  logic [4:0]  w_dec;
  logic [3:0]  w_seen_next;
  logic [15:0] w_blank_next;

  // The stability counter compares the registered pair with the one before
  // it, so the capture edge lands exactly STABLE_CYCLES edges after the pair
  // first appears on the inputs.
  assign w_same     = (r_val_q == r_val_prev) && (r_place_q == r_place_prev);
  assign w_capture  = w_same && (r_stable_cnt == C_STABLE_M1);
  assign w_q_onehot = one_hot_low(r_place_q);
  assign w_q_multi  = !w_q_onehot && (r_place_q != 4'b0000) && (r_place_q != 4'b1111);
  assign w_dec      = decode(r_val_q);

  // Blank detection counts raw samples as they enter the input stage.
  assign w_in_onehot = one_hot_low(bus.place);
  assign w_in_idle   = (bus.place == 4'b0000) || (bus.place == 4'b1111);

  always_comb begin
    w_slot = 2'd0;
    case (r_place_q)
      4'b0111: w_slot = 2'd3;
      4'b1011: w_slot = 2'd2;
      4'b1101: w_slot = 2'd1;
      default: w_slot = 2'd0;
    endcase
  end

  always_comb begin
    w_seen_next = r_seen;
    if (w_capture && w_q_onehot) begin
      w_seen_next = r_seen | ~r_place_q;
    end
  end

  always_comb begin
    w_blank_next = r_blank_cnt;
    if (w_in_onehot) begin
      w_blank_next = 16'd0;
    end else if (w_in_idle && (r_blank_cnt != C_BLANK)) begin
      w_blank_next = r_blank_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_val_q       <= 7'd0;
      r_val_prev    <= 7'd0;
      r_place_q     <= 4'd0;
      r_place_prev  <= 4'd0;
      r_stable_cnt  <= 8'd0;
      r_blank_cnt   <= 16'd0;
      r_seen        <= 4'b0000;
      r_digit[0]    <= 4'hF;
      r_digit[1]    <= 4'hF;
      r_digit[2]    <= 4'hF;
      r_digit[3]    <= 4'hF;
      r_state       <= S_SYNC;
      r_valid       <= 1'b0;
      r_frame_done  <= 1'b0;
      r_seg_err     <= 1'b0;
      r_place_err   <= 1'b0;
      r_display_off <= 1'b0;
    end else begin
      r_val_q      <= bus.val;
      r_place_q    <= bus.place;
      r_val_prev   <= r_val_q;
      r_place_prev <= r_place_q;
      r_blank_cnt  <= w_blank_next;

      if (!w_same) begin
        r_stable_cnt <= 8'd1;
      end else if (r_stable_cnt < C_STABLE) begin
        r_stable_cnt <= r_stable_cnt + 8'd1;
      end

      r_frame_done <= 1'b0;
      r_seg_err    <= 1'b0;
      r_place_err  <= 1'b0;

      if (w_capture && w_q_multi) begin
        r_place_err <= 1'b1;
      end
      if (w_capture && w_q_onehot) begin
        r_digit[w_slot] <= w_dec[3:0];
        r_seg_err       <= w_dec[4];
      end

      case (r_state)
        S_SYNC, S_RUN: begin
          if (w_seen_next == 4'b1111) begin
            r_frame_done <= 1'b1;
            r_valid      <= 1'b1;
            r_seen       <= 4'b0000;
            r_state      <= S_RUN;
          end else begin
            r_seen <= w_seen_next;
          end
          if (w_blank_next == C_BLANK) begin
            r_state       <= S_OFF;
            r_display_off <= 1'b1;
            r_valid       <= 1'b0;
            r_seen        <= 4'b0000;
          end
        end
        S_OFF: begin
          r_seen <= 4'b0000;
          if (w_capture && w_q_onehot) begin
            r_display_off <= 1'b0;
            r_seen        <= w_seen_next;
            r_state       <= S_SYNC;
          end
        end
        default: begin
          r_state <= S_SYNC;
          r_seen  <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.thous       = r_digit[3];
  assign bus.hund        = r_digit[2];
  assign bus.tens        = r_digit[1];
  assign bus.ones        = r_digit[0];
  assign bus.valid       = r_valid;
  assign bus.frame_done  = r_frame_done;
  assign bus.seg_err     = r_seg_err;
  assign bus.place_err   = r_place_err;
  assign bus.display_off = r_display_off;

endmodule
`default_nettype wire

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart to the multiplexed BCD-to-7-segment driver.
- Samples the scanned segment bus (Val) and the anode-select bus (Place), debounces each digit slot, and decodes the segment pattern back to BCD.
- Reconstructs the four displayed digits: Thous, Hund, Tens, Ones.
- Used as an on-chip display monitor and as a self-check in board-level benches.

Parameters:
- STABLE_CYCLES, 4: consecutive identical (Val, Place) samples required before a digit is accepted; legal range 2..255.
- BLANK_CYCLES, 64: consecutive "no digit selected" samples before DisplayOff asserts; legal range 2..65535.

Ports:
- Clk  input  1  system clock, all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- Val  input  7  active-low segments, bit 6 = segment A, bit 0 = segment G.
- Place  input  4  active-low anode select: 0111 = Thous, 1011 = Hund, 1101 = Tens, 1110 = Ones.
- Thous  output  4  recovered thousands digit.
- Hund  output  4  recovered hundreds digit.
- Tens  output  4  recovered tens digit.
- Ones  output  4  recovered ones digit.
- Valid  output  1  high once a complete frame has been captured since the last reset or DisplayOff.
- FrameDone  output  1  1-cycle pulse when all four slots have been captured in the current frame.
- SegErr  output  1  1-cycle pulse when a captured segment pattern is illegal.
- PlaceErr  output  1  1-cycle pulse when a stable Place has more than one low bit (excluding 0000).
- DisplayOff  output  1  level; the driver is blanked or disabled.

Behaviour:
- Clock and reset: single clock, synchronous active-high reset.
- Reset values: Thous = Hund = Tens = Ones = 4'hF; Valid, FrameDone, SegErr, PlaceErr, DisplayOff = 0. Internal: sample registers = 0, stability counter = 0, seen mask = 0000, blank counter = 0, state = SYNC.
- Reset mid-frame: discards partial captures; no pulse is emitted in the reset cycle.
- Input stage: Val and Place are registered every cycle into Val_q and Place_q. There is no async input synchronizer; the source shares Clk.
- Stability counter (8 bit):
  - if (Val_q, Place_q) equals the previous cycle's pair, increment, saturating at STABLE_CYCLES;
  - otherwise load 1.
- Capture event: occurs exactly once per stable period, on the cycle the counter steps from STABLE_CYCLES-1 to STABLE_CYCLES.
- Latency: a pair presented before edge k and held causes its digit register to update on edge k+STABLE_CYCLES.
- Capture with one-hot-low Place:
  - decode Val_q into the addressed digit register and set that slot's seen bit;
  - decode table: 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9;
  - 1111111 → 4'hF, no error;
  - any other pattern → 4'hE, and SegErr pulses on the same edge the digit updates.
- Capture with Place of two or three low bits: PlaceErr pulses; no digit or seen bit changes.
- Place = 0000 (driver disabled) or 1111 (idle): no capture.
  - The blank counter increments, saturating at BLANK_CYCLES.
  - Any one-hot-low sample clears the blank counter.
- State machine:
  - SYNC: captures update digits and the seen mask. The seen mask reaching 1111 → FrameDone pulse, Valid ← 1, seen mask ← 0000, go to RUN.
  - RUN: same capture rules. Each time the seen mask completes → FrameDone pulse, then clear. Valid stays 1.
  - OFF: DisplayOff = 1, Valid = 0, seen mask held at 0000, digits hold their last values. The first one-hot-low capture clears DisplayOff, is applied normally, and moves to SYNC.
  - Any state except OFF: blank counter reaching BLANK_CYCLES → OFF; DisplayOff and Valid change on that edge.
- Simultaneous events:
  - Capture completing the mask and SegErr on the same edge: both pulse; the frame still completes.
  - Reset has priority over every event.
- Re-capture of a slot already seen in the current frame: overwrites the digit; the mask is unchanged.
- Scan order is irrelevant; a frame completes whenever all four slots have been seen.

Test Plan:
- Reset; drive the scan 0111/Val=0010010, 1011/0000110, 1101/1001100, 1110/0100100, each held 8 cycles → Thous=2, Hund=3, Tens=4, Ones=5; FrameDone pulses once on the 4th capture (edge k+4 of the Ones slot); Valid=1.
- Hold each pair only 3 cycles with STABLE_CYCLES=4 → no digit changes, FrameDone never pulses, outputs stay 4'hF.
- Ones slot with Val=1111110 held 8 cycles → Ones=4'hE, SegErr single pulse. Val=1111111 → Ones=4'hF, no SegErr.
- Place=0011 held 8 cycles → PlaceErr single pulse; digits and seen mask unchanged.
- After a valid frame, Place=0000 for 64 cycles → DisplayOff=1 and Valid=0 on the 64th edge, digits hold. Resume scanning → DisplayOff clears on the first capture; Valid returns after a full frame.
- Assert Reset after 2 of 4 slots captured → all outputs return to reset values. A subsequent full scan yields exactly one FrameDone.
